cla_seq_ctrl: RTL
=================

CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 The parameter WIDTH SHALL default to 16 and set the operand and result width; it must be a multiple of 4 and at least 4; NIB = WIDTH/4.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The port list SHALL be as follows, with clock and reset first:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  requester has an operation to submit
- start_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A, sampled only at acceptance
- b  in  WIDTH  operand B, sampled only at acceptance
- cin  in  1  carry-in, sampled only at acceptance
- done_valid  out  1  result is available
- done_ready  in  1  consumer takes the result
- sum  out  WIDTH  registered result of a+b+cin
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  two's-complement overflow
- zero  out  1  sum == 0
- busy  out  1  high in RUN or DONE

Function
REQ-004 The block SHALL contain exactly one instance of the team's 4-bit cla adder (a, b, cin, s, pg, gg, cout) and reuse it once per nibble, low nibble first.
REQ-005 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-006 start_ready SHALL be 1 only in IDLE; busy SHALL equal NOT start_ready.
REQ-007 Acceptance SHALL occur on the edge where start_valid and start_ready are both 1: a, b and cin latch, the nibble index clears to 0, and the state goes IDLE->RUN.
REQ-008 In RUN, cycle k (k = 0..NIB-1) SHALL behave as follows:
- the cla instance gets nibble k of the latched A and B;
- its carry input is cin for k=0, otherwise the carry register;
- at the edge, s is written to sum[4k+3:4k] and cla cout to the carry register.
REQ-009 On the edge that completes nibble NIB-1, the block SHALL update its result outputs and change state:
- cout gets the final carry;
- ovf gets (A[W-1]==B[W-1]) AND (sum[W-1]!=A[W-1]), using the new sum bit;
- zero gets (final sum == 0);
- the state goes RUN->DONE.
REQ-010 Latency SHALL be fixed: with acceptance at edge T, done_valid is high from edge T+NIB. That is 4 cycles for WIDTH=16.
REQ-011 In DONE, done_valid SHALL be 1, and sum, cout, ovf and zero SHALL hold stable for as long as done_ready is 0.
REQ-012 DONE->IDLE SHALL occur on the edge where done_valid and done_ready are both 1; the result registers keep their values until the next acceptance.
REQ-013 Back-to-back operation SHALL be as follows:
- no acceptance in RUN or DONE;
- start_valid outside IDLE is ignored and does not alter state;
- minimum issue interval is NIB+2 cycles when done_ready is tied to 1.
REQ-014 Changes on a, b or cin after acceptance SHALL NOT affect the in-flight result.
REQ-015 done_ready asserted outside DONE SHALL have no effect.
REQ-016 The cla pg and gg outputs SHALL be left unused; only s and cout are consumed.

Reset
REQ-017 When rst is 1 at a clock edge, the block SHALL reset regardless of state:
- state goes to IDLE;
- sum, carry register, nibble index, cout, ovf and zero clear to 0;
- done_valid = 0, busy = 0, start_ready = 1 after the edge.
REQ-018 Reset SHALL take priority over acceptance and completion in the same cycle.
REQ-019 A reset during RUN or DONE SHALL discard the operation; done_valid is not asserted for it.
REQ-020 Reset mid-operation SHALL NOT corrupt later operations; the first operation after reset produces a correct result.

Verification (WIDTH=16)
REQ-021 Reset: hold rst=1 for 2 cycles, then release, and the bench SHALL observe the following:
- start_ready=1, busy=0;
- done_valid=0, sum=0x0000;
- cout=0, ovf=0, zero=0.
REQ-022 Basic add: a=0x1234, b=0x4321, cin=0, with done_ready=1, and the bench SHALL observe the following:
- done_valid rises exactly 4 cycles after acceptance;
- sum=0x5555, cout=0, ovf=0, zero=0.
REQ-023 Full carry ripple: a=0xFFFF, b=0x0000, cin=1, and the bench SHALL observe sum=0x0000, cout=1, ovf=0, zero=1.
REQ-024 Signed overflow: a=0x7FFF, b=0x0001, cin=0, and the bench SHALL observe sum=0x8000, cout=0, ovf=1; then a=0x8000, b=0x8000 SHALL give sum=0x0000, cout=1, ovf=1, zero=1.
REQ-025 Backpressure: hold done_ready=0 for 3 cycles in DONE while start_valid=1 with new operands, and the bench SHALL observe the following:
- done_valid and sum (0x5555) stay stable;
- start_ready stays 0 and no acceptance occurs;
- done_ready=1 returns the block to IDLE the next cycle.
REQ-026 Reset mid-RUN: pulse rst=1 after 2 nibbles of a=0x00FF+0x0001, and the bench SHALL observe the following:
- IDLE on the next edge, done_valid never rises;
- a following 0x0F0F+0x00F1 gives sum=0x1000, cout=0.

Source files
------------

// File: rtl/cla_seq_ctrl.sv
// rtl/cla_seq_ctrl.sv - nibble-serial adder sequencer built around one 4-bit CLA
//
// cla4: 4-bit carry-lookahead adder slice.
//   a, b   in  4   operand nibbles
//   cin    in  1   carry into bit 0
//   s      out 4   sum nibble
//   pg     out 1   group propagate
//   gg     out 1   group generate
//   cout   out 1   carry out of bit 3
//
// cla_seq_ctrl: adds two WIDTH-bit operands with a single cla4 instance.
// It processes one nibble per cycle, starting with the low nibble.
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous active-high reset
//   start_valid  in   1      request to start an add
//   start_ready  out  1      high in IDLE only
//   a, b         in   WIDTH  operands, latched at acceptance
//   cin          in   1      carry-in, latched at acceptance
//   done_valid   out  1      high in DONE
//   done_ready   in   1      consumer takes the result
//   sum          out  WIDTH  result of a+b+cin
//   cout         out  1      carry out of bit WIDTH-1
//   ovf          out  1      two's-complement overflow
//   zero         out  1      sum == 0
//   busy         out  1      high in RUN or DONE

module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       pg,
    output logic       gg,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign pg   = &p;
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign cout = gg | (pg & cin);
    assign s    = p ^ c;
endmodule

module cla_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);
    localparam int NIB  = WIDTH / 4;
    // A one-nibble build still needs a 1-bit index register.
    localparam int NIBW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [NIBW-1:0] LAST_NIB = NIBW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              cin_q;
    logic [NIBW-1:0]   nib_q;
    logic              carry_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              zero_q;

    logic [3:0]        cla_a;
    logic [3:0]        cla_b;
    logic              cla_cin;
    logic [3:0]        cla_s;
    logic              cla_pg;
    logic              cla_gg;
    logic              cla_cout;

    logic [WIDTH-1:0]  sum_d;
    logic              ovf_d;
    logic              zero_d;
    logic [NIBW+1:0]   bit_base;

    // Group propagate/generate are only meaningful for a wider lookahead
    // tree; this sequencer chains the slice through carry_q instead.
    logic              unused_cla;
    assign unused_cla = cla_pg ^ cla_gg;

    cla4 u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (cla_cin),
        .s    (cla_s),
        .pg   (cla_pg),
        .gg   (cla_gg),
        .cout (cla_cout)
    );

    assign bit_base = {nib_q, 2'b00};

    always_comb begin
        cla_a   = a_q[bit_base +: 4];
        cla_b   = b_q[bit_base +: 4];
        cla_cin = (nib_q == '0) ? cin_q : carry_q;

        // Merge the new nibble so the flags see the completed sum in the
        // same cycle it is written.
        sum_d                = sum_q;
        sum_d[bit_base +: 4] = cla_s;
        ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
        zero_d = (sum_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            nib_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        cin_q   <= cin;
                        nib_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= cla_cout;
                    if (nib_q == LAST_NIB) begin
                        cout_q  <= cla_cout;
                        ovf_q   <= ovf_d;
                        zero_q  <= zero_d;
                        state_q <= DONE;
                    end else begin
                        nib_q <= nib_q + 1'b1;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = ~start_ready;
    assign done_valid  = (state_q == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign zero        = zero_q;
endmodule
